sccb_slave: RTL
===============

# sccb_slave

SCCB/I2C responder for the camera configuration path: it decodes the frames the configuration master issues (7-bit device address, 16-bit register address, 8-bit data) and maps them onto a simple register-file port. Writes use auto-increment, and reads are served from a register pointer that is kept across transactions. It is the target end of the camera configuration link and serves two purposes: the bench model for the configuration master, and an on-chip register bank that an external controller can program.

## Interface
- DEV_ADDR, 7'h3C, 7-bit device address this block answers to (8-bit write/read bytes 0x78/0x79).
- clk  input  1  system clock; must run at ≥ 16× the SCL frequency.
- rst  input  1  synchronous, active-high reset.
- scl_in  input  1  raw SCL from the pad; asynchronous.
- sda_in  input  1  raw SDA from the pad; asynchronous.
- sda_out_en  output  1  1 = pull SDA low. The pad does sda = sda_out_en ? 1'b0 : 1'bz, so this block never drives a 1.
- wr_addr  output  16  register address of the current write.
- wr_data  output  8  data of the current write.
- wr_vld  output  1  one-cycle strobe; wr_addr and wr_data are valid while it is high.
- rd_addr  output  16  register address being fetched.
- rd_req  output  1  one-cycle fetch strobe.
- rd_data  input  8  read data; must be valid exactly 1 clk after rd_req.
- busy  output  1  high from an address-matched START until the next STOP.

## Operation
- Input conditioning: scl_in and sda_in each pass through 2 sync flops and then 1 history flop.
  - scl_rise / scl_fall are single-cycle edge pulses.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- Bit handling: SDA is sampled on scl_rise. sda_out_en changes only on the clk after scl_fall.
- START, in any state, including a repeated START: bit counter cleared, sda_out_en = 0, go to DEV.
- STOP, in any state: go to IDLE, sda_out_en = 0, busy = 0. The register pointer ptr[15:0] is retained.
- States: IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE.
- DEV: shift in 8 bits, MSB first.
  - If bits[7:1] == DEV_ADDR: ACK and set busy.
  - Otherwise: no ACK, go to IGNORE. IGNORE is left only by START or STOP.
- ACK slot: on the scl_fall after the 8th bit, sda_out_en = 1. On the next scl_fall, sda_out_en = 0.
- Write, R/W = 0:
  - DEV_ACK → AHI. AHI fills ptr[15:8], then AHI_ACK.
  - AHI_ACK → ALO. ALO fills ptr[7:0], then ALO_ACK.
  - ALO_ACK → WDAT. Each completed WDAT byte pulses wr_vld, with wr_addr = ptr and wr_data = byte, on the cycle after its 8th scl_rise.
  - Then ptr += 1, and the byte is ACKed (WDAT_ACK → WDAT). Writes are unlimited.
- Read, R/W = 1:
  - On the clk after the 8th DEV scl_rise: rd_req = 1 and rd_addr = ptr. rd_data is latched into shift register tx[7:0] one clk later.
  - DEV_ACK → RDAT.
  - RDAT: sda_out_en = ~tx[7] is applied on the scl_fall that ends the ACK. tx shifts left on each following scl_fall, 8 bits total. On the scl_fall after bit 8, sda_out_en = 0, ptr += 1, state RDAT_ACK.
  - RDAT_ACK samples the master's bit on scl_rise:
    - 0 (ACK): rd_req for the new ptr, then RDAT.
    - 1 (NACK): go to IGNORE, SDA released.
- The pointer wraps 0xFFFF → 0x0000 with no flag.
- A byte cut short by START or STOP is discarded: no wr_vld, ptr unchanged.

## Timing
- Reset values: sda_out_en = 0, wr_vld = 0, rd_req = 0, busy = 0, wr_addr = 0, wr_data = 0, rd_addr = 0, ptr = 0, state IDLE.
- Event detection latency: 3 clk from a pad edge to its scl_rise / scl_fall / START / STOP pulse.
- SDA drive change: 1 clk after scl_fall is detected, i.e. 4 clk after the pad SCL falls. This must be < tLOW; the ≥ 16× clock guarantees it.
- Simultaneous events: if START/STOP coincides with scl_fall in the same clk, START/STOP takes priority.
- Reset asserted mid-transaction: SDA is released in the next cycle and any pending wr_vld / rd_req is dropped. After reset the block stays in IDLE, ignoring bits, until a fresh START.
- wr_vld and rd_req are never high in the same cycle.

## Test plan
- Single write, START 0x78 0x30 0x08 0x82 STOP → ACK on all 4 bytes; one wr_vld with wr_addr = 0x3008, wr_data = 0x82; busy falls after STOP.
- Burst write, 0x78 0x38 0x00 then 0x11 0x22 0x33 → three wr_vld pulses at 0x3800, 0x3801, 0x3802; ptr ends at 0x3803.
- Random read: write phase 0x78 0x30 0x0A, STOP; then START 0x79, bench returns rd_data 0x56 then 0x40, master sends ACK then NACK → SDA carries 0x56 then 0x40; rd_addr = 0x300A then 0x300B; SDA released after NACK.
- Address mismatch, START 0x7A 0x12 ... STOP → no ACK, sda_out_en stays 0, no wr_vld / rd_req, busy stays 0.
- Wrap and abort: ptr = 0xFFFF, write 0xAA then 0xBB → wr_addr 0xFFFF then 0x0000. Then STOP after 4 bits of a third byte → no third wr_vld.
- Reset during the ACK of an address byte → sda_out_en = 0 on the next clk; subsequent bits are ignored until a new START, which then completes normally.

Source files
------------

// File: rtl/sccb_slave_if.sv
// sccb_slave_if: bus bundle between the SCCB responder and its surroundings.
// Signals:
//   scl_in, sda_in  raw pad levels (asynchronous to clk)
//   sda_out_en      1 = pull SDA low (open drain, never drives a 1)
//   wr_addr/wr_data/wr_vld  register-file write strobe with address and data
//   rd_addr/rd_req  register-file fetch strobe; rd_data returns 1 clk later
//   busy            transaction in progress for this device
// Modports: slave = the responder, master = pad + register file side.
interface sccb_slave_if;
  logic        scl_in;
  logic        sda_in;
  logic        sda_out_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_vld;
  logic [15:0] rd_addr;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic        busy;

  modport slave (
    input  scl_in, sda_in, rd_data,
    output sda_out_en, wr_addr, wr_data, wr_vld, rd_addr, rd_req, busy
  );

  modport master (
    output scl_in, sda_in, rd_data,
    input  sda_out_en, wr_addr, wr_data, wr_vld, rd_addr, rd_req, busy
  );
endinterface

// File: rtl/sccb_slave.sv
// sccb_slave: SCCB/I2C responder mapping 7-bit device address, 16-bit
// register address and 8-bit data frames onto a register-file port.
// Writes auto-increment the register pointer; reads start at the pointer,
// which survives STOP so a read can follow an address-only write.
// Ports:
//   clk  system clock, at least 16x the SCL rate
//   rst  synchronous active-high reset
//   bus  sccb_slave_if.slave (pad levels, SDA pull-down, register-file port)
module sccb_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h3C
) (
  input logic        clk,
  input logic        rst,
  sccb_slave_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK,
    WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE
  } state_t;

  // Two sync flops plus one history flop per pad line. Reset to the idle
  // bus level so leaving reset creates no spurious START/STOP.
  logic [1:0] scl_sync_reg, sda_sync_reg;
  logic       scl_hist_reg, sda_hist_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_hist_reg <= 1'b1;
      sda_hist_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], bus.scl_in};
      sda_sync_reg <= {sda_sync_reg[0], bus.sda_in};
      scl_hist_reg <= scl_sync_reg[1];
      sda_hist_reg <= sda_sync_reg[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_s      = scl_sync_reg[1];
  assign sda_s      = sda_sync_reg[1];
  assign scl_rise   = scl_s & ~scl_hist_reg;
  assign scl_fall   = ~scl_s & scl_hist_reg;
  assign start_cond = scl_s & scl_hist_reg & sda_hist_reg & ~sda_s;
  assign stop_cond  = scl_s & scl_hist_reg & ~sda_hist_reg & sda_s;

  state_t      state_reg, state_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  rx_reg, rx_next;
  logic [7:0]  tx_reg, tx_next;
  logic [15:0] ptr_reg, ptr_next;
  logic        sda_out_en_reg, sda_out_en_next;
  logic        busy_reg, busy_next;
  logic        rw_reg, rw_next;
  logic        ack_seen_reg, ack_seen_next;
  logic        wr_vld_reg, wr_vld_next;
  logic [15:0] wr_addr_reg, wr_addr_next;
  logic [7:0]  wr_data_reg, wr_data_next;
  logic        rd_req_reg, rd_req_next;
  logic [15:0] rd_addr_reg, rd_addr_next;
  logic        rd_pending_reg, rd_pending_next;

  logic [7:0] rx_byte;
  logic       last_bit;
  assign rx_byte  = {rx_reg[6:0], sda_s};
  assign last_bit = (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= 3'd0;
      rx_reg         <= 8'd0;
      tx_reg         <= 8'd0;
      ptr_reg        <= 16'd0;
      sda_out_en_reg <= 1'b0;
      busy_reg       <= 1'b0;
      rw_reg         <= 1'b0;
      ack_seen_reg   <= 1'b0;
      wr_vld_reg     <= 1'b0;
      wr_addr_reg    <= 16'd0;
      wr_data_reg    <= 8'd0;
      rd_req_reg     <= 1'b0;
      rd_addr_reg    <= 16'd0;
      rd_pending_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      rx_reg         <= rx_next;
      tx_reg         <= tx_next;
      ptr_reg        <= ptr_next;
      sda_out_en_reg <= sda_out_en_next;
      busy_reg       <= busy_next;
      rw_reg         <= rw_next;
      ack_seen_reg   <= ack_seen_next;
      wr_vld_reg     <= wr_vld_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      rd_req_reg     <= rd_req_next;
      rd_addr_reg    <= rd_addr_next;
      rd_pending_reg <= rd_pending_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    rx_next         = rx_reg;
    tx_next         = tx_reg;
    ptr_next        = ptr_reg;
    sda_out_en_next = sda_out_en_reg;
    busy_next       = busy_reg;
    rw_next         = rw_reg;
    ack_seen_next   = ack_seen_reg;
    wr_vld_next     = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    rd_req_next     = 1'b0;
    rd_addr_next    = rd_addr_reg;
    rd_pending_next = rd_req_reg;
    // Register file answers one clk after the fetch strobe.
    if (rd_pending_reg) tx_next = bus.rd_data;

    case (state_reg)
      DEV, AHI, ALO, WDAT: begin
        if (scl_rise) begin
          rx_next      = rx_byte;
          bit_cnt_next = bit_cnt_reg + 3'd1;  // wraps to 0 after the 8th bit
          if (last_bit) begin
            if (state_reg == DEV) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                busy_next  = 1'b1;
                rw_next    = rx_byte[0];
                state_next = DEV_ACK;
                if (rx_byte[0]) begin
                  rd_req_next  = 1'b1;
                  rd_addr_next = ptr_reg;
                end
              end else begin
                state_next = IGNORE;
              end
            end else if (state_reg == AHI) begin
              ptr_next[15:8] = rx_byte;
              state_next     = AHI_ACK;
            end else if (state_reg == ALO) begin
              ptr_next[7:0] = rx_byte;
              state_next    = ALO_ACK;
            end else begin
              wr_vld_next  = 1'b1;
              wr_addr_next = ptr_reg;
              wr_data_next = rx_byte;
              ptr_next     = ptr_reg + 16'd1;
              state_next   = WDAT_ACK;
            end
          end
        end
      end

      // First scl_fall opens the ACK slot, second one closes it.
      DEV_ACK, AHI_ACK, ALO_ACK, WDAT_ACK: begin
        if (scl_fall) begin
          if (!sda_out_en_reg) begin
            sda_out_en_next = 1'b1;
          end else begin
            sda_out_en_next = 1'b0;
            case (state_reg)
              DEV_ACK: begin
                if (rw_reg) begin
                  sda_out_en_next = ~tx_reg[7];
                  state_next      = RDAT;
                end else begin
                  state_next = AHI;
                end
              end
              AHI_ACK: state_next = ALO;
              default: state_next = WDAT;
            endcase
          end
        end
      end

      // Bit 7 is already on SDA when RDAT is entered; each fall moves on.
      RDAT: begin
        if (scl_fall) begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (last_bit) begin
            sda_out_en_next = 1'b0;
            ptr_next        = ptr_reg + 16'd1;
            state_next      = RDAT_ACK;
          end else begin
            tx_next         = {tx_reg[6:0], 1'b0};
            sda_out_en_next = ~tx_reg[6];
          end
        end
      end

      RDAT_ACK: begin
        if (scl_rise) begin
          if (sda_s) begin
            state_next = IGNORE;
          end else begin
            rd_req_next   = 1'b1;
            rd_addr_next  = ptr_reg;
            ack_seen_next = 1'b1;
          end
        end else if (scl_fall && ack_seen_reg) begin
          ack_seen_next   = 1'b0;
          sda_out_en_next = ~tx_reg[7];
          state_next      = RDAT;
        end
      end

      default: ;
    endcase

    // Bus conditions override bit handling; a partial byte is discarded.
    if (stop_cond || start_cond) begin
      state_next      = stop_cond ? IDLE : DEV;
      bit_cnt_next    = 3'd0;
      sda_out_en_next = 1'b0;
      ack_seen_next   = 1'b0;
      ptr_next        = ptr_reg;
      wr_vld_next     = 1'b0;
      rd_req_next     = 1'b0;
      if (stop_cond) busy_next = 1'b0;
    end
  end

  assign bus.sda_out_en = sda_out_en_reg;
  assign bus.busy       = busy_reg;
  assign bus.wr_vld     = wr_vld_reg;
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = wr_data_reg;
  assign bus.rd_req     = rd_req_reg;
  assign bus.rd_addr    = rd_addr_reg;

endmodule
